// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared types and helpers for the sequential slice adder.
//   add_state_t : two-state controller encoding (IDLE waits for start,
//                 RUN walks the slices from LSB to MSB).
//   ctrWidth()  : width of the slice counter for a given slice count,
//                 never smaller than one bit so a single-slice build
//                 still has a legal counter register.
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic {IDLE, RUN} add_state_t;

  // clog2 of the slice count, clamped to at least 1 bit
  function automatic int ctrWidth(input int nsl);
    if (nsl <= 2) begin
      return 1;
    end
    return $clog2(nsl);
  endfunction

endpackage

// File: rtl/rca_n.sv
// ---------------------------------------------------------------------------
// fa / rca_n
// fa    : single-bit full adder.
//   i_a, i_b, i_cin : addend bits and carry in
//   o_s, o_cout     : sum bit and carry out
// rca_n : N-bit combinational ripple-carry adder built from a chain of fa
//         instances.
//   A, B   [N-1:0] : addends
//   Cin            : carry into bit 0
//   S      [N-1:0] : sum
//   Cout           : carry out of bit N-1
//   c_msb          : carry into bit N-1, used for two's-complement overflow
// ---------------------------------------------------------------------------
module fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  // Classic sum/majority equations
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

module rca_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         c_msb
);

  logic [N:0] w_carry;

  // Carry chain: w_carry[i] is the carry into bit i, so the chain starts at
  // Cin and its last element is the carry out of the MSB
  assign w_carry[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    fa u_fa (
      .i_a   (A[i]),
      .i_b   (B[i]),
      .i_cin (w_carry[i]),
      .o_s   (S[i]),
      .o_cout(w_carry[i+1])
    );
  end

  // Export both ends of the MSB stage so the caller can detect overflow
  assign Cout  = w_carry[N];
  assign c_msb = w_carry[N-1];

endmodule

// File: rtl/seq_slice_adder.sv
// ---------------------------------------------------------------------------
// seq_slice_adder
// Multi-cycle ripple-carry adder: computes {Cout,S} = A + B + Cin, SLICE bits
// per clock, holding the inter-slice carry in a register so the critical
// path is one SLICE-bit ripple regardless of WIDTH.
//
// Parameters
//   WIDTH : operand/sum width, must be a multiple of SLICE
//   SLICE : bits added per clock, 1 <= SLICE <= WIDTH
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request an add, accepted only while busy is low
//   A, B  : operands, sampled on the accepting edge only
//   Cin   : carry in, sampled on the accepting edge only
//   busy  : high while slices are being processed
//   done  : one-cycle pulse when S/Cout are valid (busy already low)
//   S     : sum, held until the next accepted start
//   Cout  : carry out of bit WIDTH-1, held like S
//   ovf   : signed overflow, only when OVF_DETECT_EN is defined
//
// Build option
//   OVF_DETECT_EN : adds the ovf port and its overflow register.
// ---------------------------------------------------------------------------
module seq_slice_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef OVF_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSL = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int CW  = ctrWidth(NSL);
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSL - 1);

  // Refuse to elaborate a configuration that cannot tile the operand evenly
  if ((SLICE < 1) || (SLICE > WIDTH) ||
      ((WIDTH % ((SLICE > 0) ? SLICE : 1)) != 0)) begin : g_badParams
    $error("seq_slice_adder: WIDTH must be a non-zero multiple of SLICE");
  end

  add_state_t       r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_done;
  logic             r_busy;

  int               w_base;
  logic [SLICE-1:0] w_aSlice;
  logic [SLICE-1:0] w_bSlice;
  logic [SLICE-1:0] w_sliceSum;
  logic             w_sliceCout;

`ifdef OVF_DETECT_EN
  logic             r_ovf;
  logic             w_cMsb;
`endif

  // Bit offset of the slice being processed this cycle, and the matching
  // operand slices taken from the latched copies (never the live inputs)
  assign w_base   = int'(r_cnt) * SLICE;
  assign w_aSlice = r_opA[w_base +: SLICE];
  assign w_bSlice = r_opB[w_base +: SLICE];

  // The one and only ripple chain; it is reused for every slice with the
  // registered carry from the previous slice feeding its carry in
  rca_n #(
    .N(SLICE)
  ) u_rca (
    .A    (w_aSlice),
    .B    (w_bSlice),
    .Cin  (r_carry),
    .S    (w_sliceSum),
    .Cout (w_sliceCout),
`ifdef OVF_DETECT_EN
    .c_msb(w_cMsb)
`else
    .c_msb()
`endif
  );

  // Controller and datapath registers. IDLE latches operands and clears the
  // result on an accepted start; RUN writes one slice of the sum per edge and
  // on the last slice publishes Cout, raises done and drops back to IDLE, so
  // a start seen during the done cycle is accepted immediately. done
  // defaults low every edge, which makes it a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_opA   <= '0;
      r_opB   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef OVF_DETECT_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_opA   <= A;
            r_opB   <= B;
            r_carry <= Cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
`ifdef OVF_DETECT_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        RUN: begin
          r_sum[w_base +: SLICE] <= w_sliceSum;
          r_carry                <= w_sliceCout;
          r_cnt                  <= r_cnt + CW'(1);
          if (r_cnt == LAST_SLICE) begin
            r_cout  <= w_sliceCout;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
`ifdef OVF_DETECT_EN
            r_ovf   <= w_cMsb ^ w_sliceCout;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from registers
  assign busy = r_busy;
  assign done = r_done;
  assign S    = r_sum;
  assign Cout = r_cout;
`ifdef OVF_DETECT_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_seq_slice_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_slice_adder
// Exercises three builds of seq_slice_adder side by side:
//   u_dut32  : WIDTH=32, SLICE=8  (index 0)
//   u_dut12w : WIDTH=12, SLICE=12 (index 1)
//   u_dut12n : WIDTH=12, SLICE=1  (index 2)
// Expected results come from a hand-filled vector table and from a plain
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_slice_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] expS;
    logic        expC;
    logic        expOvf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  startV;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        cin;
  logic [2:0]  busyV;
  logic [2:0]  doneV;
  logic [2:0]  coutV;
  logic [31:0] s32;
  logic [11:0] s12w;
  logic [11:0] s12n;
`ifdef OVF_DETECT_EN
  logic        ovf32;
  logic        ovf12w;
  logic        ovf12n;
`endif

  int nChecks = 0;
  int nFail   = 0;

  vec_t vecs[8];

  always #5 clk = ~clk;

  seq_slice_adder #(.WIDTH(32), .SLICE(8)) u_dut32 (
    .clk(clk), .rst(rst), .start(startV[0]), .A(opA), .B(opB), .Cin(cin),
    .busy(busyV[0]), .done(doneV[0]), .S(s32), .Cout(coutV[0])
`ifdef OVF_DETECT_EN
    , .ovf(ovf32)
`endif
  );

  seq_slice_adder #(.WIDTH(12), .SLICE(12)) u_dut12w (
    .clk(clk), .rst(rst), .start(startV[1]), .A(opA[11:0]), .B(opB[11:0]),
    .Cin(cin), .busy(busyV[1]), .done(doneV[1]), .S(s12w), .Cout(coutV[1])
`ifdef OVF_DETECT_EN
    , .ovf(ovf12w)
`endif
  );

  seq_slice_adder #(.WIDTH(12), .SLICE(1)) u_dut12n (
    .clk(clk), .rst(rst), .start(startV[2]), .A(opA[11:0]), .B(opB[11:0]),
    .Cin(cin), .busy(busyV[2]), .done(doneV[2]), .S(s12n), .Cout(coutV[2])
`ifdef OVF_DETECT_EN
    , .ovf(ovf12n)
`endif
  );

  // Reference: {carry, sum} of an unsigned width-bit add
  function automatic logic [32:0] refAdd(input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input int width);
    logic [63:0] m;
    logic [63:0] r;
    m = (64'd1 << width) - 64'd1;
    r = (64'(a) & m) + (64'(b) & m) + 64'(c);
    return {r[width], r[31:0] & m[31:0]};
  endfunction

  // Reference: true signed sum falls outside the 32-bit two's-complement range
  function automatic logic refOvf32(input logic [31:0] a, input logic [31:0] b, input logic c);
    longint r;
    r = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic logic [31:0] sumOf(input int which);
    case (which)
      0:       return s32;
      1:       return {20'd0, s12w};
      default: return {20'd0, s12n};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands on a falling edge and pulse start across one rising edge
  task automatic applyStimulus(input int which, input logic [31:0] a, input logic [31:0] b,
                               input logic c);
    @(negedge clk);
    opA = a;
    opB = b;
    cin = c;
    startV[which] = 1'b1;
    @(posedge clk);
    #1 startV[which] = 1'b0;
  endtask

  // Wait for done (bounded); lat = cycles from the start edge, -1 on timeout
  task automatic waitDone(input int which, input bit scramble, output int lat, output int busyCnt);
    lat = -1;
    busyCnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (doneV[which]) begin
        lat = i - 1;
        break;
      end
      if (busyV[which]) busyCnt++;
      if (scramble) begin
        opA = $urandom;
        opB = $urandom;
        cin = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int bc;
    int doneAt[$];
    int pulses;
    logic [32:0] exp;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h12345678, 32'h0FEDCBA9, 1'b1, 32'h22222222, 1'b0, 1'b0};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[6] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[7] = '{32'h00FFFF00, 32'h00000100, 1'b0, 32'h01000000, 1'b0, 1'b0};

    rst = 1'b1;
    startV = '0;
    opA = '0;
    opB = '0;
    cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    checkOutput("resetBusy", 64'(busyV), 64'd0);
    checkOutput("resetDone", 64'(doneV), 64'd0);
    checkOutput("resetCout", 64'(coutV), 64'd0);
    checkOutput("resetS32", 64'(s32), 64'd0);
    checkOutput("resetS12w", 64'(s12w), 64'd0);
    checkOutput("resetS12n", 64'(s12n), 64'd0);
`ifdef OVF_DETECT_EN
    checkOutput("resetOvf", 64'(ovf32), 64'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, vecs[i].a, vecs[i].b, vecs[i].cin);
      waitDone(0, 1'b0, lat, bc);
      checkOutput($sformatf("vec%0dLatency", i), 64'(lat), 64'd4);
      checkOutput($sformatf("vec%0dBusyCycles", i), 64'(bc), 64'd4);
      checkOutput($sformatf("vec%0dBusyAtDone", i), 64'(busyV[0]), 64'd0);
      checkOutput($sformatf("vec%0dS", i), 64'(s32), 64'(vecs[i].expS));
      checkOutput($sformatf("vec%0dCout", i), 64'(coutV[0]), 64'(vecs[i].expC));
`ifdef OVF_DETECT_EN
      checkOutput($sformatf("vec%0dOvf", i), 64'(ovf32), 64'(vecs[i].expOvf));
`endif
    end

    repeat (2) @(negedge clk);
    checkOutput("donePulseEnds", 64'(doneV[0]), 64'd0);
    checkOutput("sumHolds", 64'(s32), 64'(vecs[7].expS));

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      c = 1'($urandom_range(0, 1));
      exp = refAdd(a, b, c, 32);
      applyStimulus(0, a, b, c);
      waitDone(0, 1'b1, lat, bc);
      checkOutput($sformatf("rnd%0dLatency", i), 64'(lat), 64'd4);
      checkOutput($sformatf("rnd%0dS", i), 64'(s32), 64'(exp[31:0]));
      checkOutput($sformatf("rnd%0dCout", i), 64'(coutV[0]), 64'(exp[32]));
`ifdef OVF_DETECT_EN
      checkOutput($sformatf("rnd%0dOvf", i), 64'(ovf32), 64'(refOvf32(a, b, c)));
`endif
    end

    @(negedge clk);
    opA = 32'h0000FFFF;
    opB = 32'h00010001;
    cin = 1'b1;
    startV[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      checkOutput($sformatf("b2bBusy%0d", i), 64'(busyV[0]), 64'(!doneV[0]));
      if (doneV[0]) begin
        doneAt.push_back(i);
        checkOutput($sformatf("b2bS%0d", i), 64'(s32), 64'h00020001);
      end
    end
    startV[0] = 1'b0;
    checkOutput("b2bPulseCount", 64'(doneAt.size()), 64'd6);
    for (int i = 1; i < doneAt.size(); i++) begin
      checkOutput($sformatf("b2bGap%0d", i), 64'(doneAt[i] - doneAt[i-1]), 64'd5);
    end
    @(negedge clk);
    checkOutput("b2bIdleAfter", 64'(busyV[0]), 64'd0);

    applyStimulus(0, 32'h11111111, 32'h22222222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortBusy", 64'(busyV[0]), 64'd0);
    checkOutput("abortDone", 64'(doneV[0]), 64'd0);
    checkOutput("abortS", 64'(s32), 64'd0);
    checkOutput("abortCout", 64'(coutV[0]), 64'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (doneV[0]) pulses++;
    end
    checkOutput("abortNoDone", 64'(pulses), 64'd0);
    applyStimulus(0, vecs[1].a, vecs[1].b, vecs[1].cin);
    waitDone(0, 1'b0, lat, bc);
    checkOutput("afterAbortLatency", 64'(lat), 64'd4);
    checkOutput("afterAbortS", 64'(s32), 64'h22222222);
    checkOutput("afterAbortCout", 64'(coutV[0]), 64'd0);

    for (int w = 1; w <= 2; w++) begin
      applyStimulus(w, 32'h800, 32'h800, 1'b0);
      waitDone(w, 1'b0, lat, bc);
      checkOutput($sformatf("w12dut%0dLatency", w), 64'(lat), (w == 1) ? 64'd1 : 64'd12);
      checkOutput($sformatf("w12dut%0dS", w), 64'(sumOf(w)), 64'd0);
      checkOutput($sformatf("w12dut%0dCout", w), 64'(coutV[w]), 64'd1);
      for (int i = 0; i < 4; i++) begin
        a = $urandom;
        b = $urandom;
        c = 1'($urandom_range(0, 1));
        exp = refAdd(a, b, c, 12);
        applyStimulus(w, a, b, c);
        waitDone(w, 1'b1, lat, bc);
        checkOutput($sformatf("w12dut%0dRnd%0dS", w, i), 64'(sumOf(w)), 64'(exp[31:0]));
        checkOutput($sformatf("w12dut%0dRnd%0dCout", w, i), 64'(coutV[w]), 64'(exp[32]));
      end
    end

    $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
    $finish;
  end

endmodule

// File: doc/seq_slice_adder.md
Name: seq_slice_adder

Overview:
- Multi-cycle, parametrised ripple-carry adder: adds two WIDTH-bit operands plus a carry-in, SLICE bits per clock.
- Carry is held in a register between slices, so logic depth is one SLICE-bit ripple chain regardless of WIDTH.
- Successor to the fixed-width combinational RCA blocks; used by the datapath wherever wide adds can trade latency for area and timing.
- Handshake: start/busy/done.

Parameters:
- WIDTH, 32: operand and sum width in bits; must be a multiple of SLICE.
- SLICE, 8: bits added per cycle; 1 <= SLICE <= WIDTH.

Ports:
- clk  input  1: rising-edge clock.
- rst  input  1: synchronous, active-high reset.
- start  input  1: request an add; accepted only when busy==0.
- A  input  WIDTH: operand A; sampled on the accepting edge only.
- B  input  WIDTH: operand B; sampled on the accepting edge only.
- Cin  input  1: carry in; sampled on the accepting edge only.
- busy  output  1: high while an add is in progress.
- done  output  1: single-cycle pulse; S/Cout are valid.
- S  output  WIDTH: sum; holds its value until the next accepted start.
- Cout  output  1: carry out of the MSB; holds like S.
- ovf  output  1: signed overflow; present only with OVF_DETECT_EN.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, S=0, Cout=0, ovf=0, slice counter=0, carry register=0.
- NSL = WIDTH/SLICE. Elaboration fails if WIDTH%SLICE != 0 or SLICE==0.
- States:
  - IDLE: busy=0. On edge with start=1, latch A, B, Cin into operand registers; clear counter; go to RUN.
  - RUN: busy=1. Each edge adds slice k = counter: bits [k*SLICE +: SLICE] of A_reg, B_reg, plus carry_reg. Write the slice sum into S[k*SLICE +: SLICE]; the slice carry-out goes to carry_reg. Counter increments.
  - RUN exit: on the edge processing slice NSL-1, Cout <= final carry, done <= 1, state <= IDLE.
- Latency: start sampled at edge E0; done high in the cycle after edge E(NSL), i.e. NSL cycles after the start cycle. For SLICE==WIDTH, latency is 1.
- done is high for exactly one cycle, while busy is already 0. A start asserted during the done cycle is accepted (back-to-back throughput: one result per NSL+1 cycles).
- start while busy=1 is ignored, with no queuing. A, B, Cin may change freely while busy.
- S during RUN is partially updated; it is valid only in and after the done cycle. Upper slices clear to 0 on accept.
- Reset mid-RUN aborts: return to IDLE, all outputs at reset values, no done pulse.
- Arithmetic: unsigned modulo 2^WIDTH. Cout is the carry out of bit WIDTH-1. Result equals {Cout,S} = A + B + Cin.

Optional Feature:
- Macro: OVF_DETECT_EN.
- Defined:
  - The ovf port exists.
  - On the final slice, ovf <= carry into MSB XOR carry out of MSB (two's-complement overflow).
  - ovf is updated together with Cout, holds until the next accept, and clears on accept.
- Undefined: no ovf port and no associated logic; the rest of the behaviour is identical.

Decomposition:
- Package adder_pkg contains:
  - typedef enum logic {IDLE, RUN} add_state_t;
  - a function returning the counter width, clog2(NSL) with minimum 1.
- Sub-module rca_n (parameter N): N-bit combinational ripple adder built as an array of FA instances, with ports A, B, Cin, S, Cout.
  - Instantiated once with N=SLICE.
  - Exposes the carry into the MSB (c_msb) for overflow detection.

Test Plan:
- WIDTH=32, SLICE=8: A=0xFFFFFFFF, B=0x00000001, Cin=0, start 1 cycle -> busy for 4 cycles, done 4 cycles after start, S=0x00000000, Cout=1.
- A=0x12345678, B=0x0FEDCBA9, Cin=1 -> S=0x22222222, Cout=0. Drive random A/B while busy -> result unchanged.
- start held high continuously -> new accept in each done cycle; one done pulse every 5 cycles; every start during busy ignored.
- Assert rst for 1 cycle at RUN slice 2 -> next cycle busy=0, done=0, S=0, Cout=0; no done pulse follows. A new start completes correctly.
- WIDTH=12, SLICE=12 and WIDTH=12, SLICE=1 -> latency 1 and 12 respectively. A=0x800, B=0x800 -> S=0x000, Cout=1.
- OVF_DETECT_EN, WIDTH=32: A=0x7FFFFFFF, B=1 -> ovf=1, Cout=0. A=0xFFFFFFFF, B=1 -> ovf=0, Cout=1.
